lut_page_loader: RTL and testbench

LUT_PAGE_LOADER -- requirements
Module: lut_page_loader

---
 rtl/lut_page_loader_if.sv | 27 ++
 rtl/lut_page_loader.sv | 83 ++++++++
 tb/tb_lut_page_loader.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_page_loader_if.sv
// Word-stream and page-memory signal bundle for lut_page_loader.
// The loader sits on the slave modport; the word source and memory side use master.
interface lut_page_loader_if #(
  parameter int QUAN_SIZE       = 3,
  parameter int BANK_INTERLEAVE = 2,
  parameter int ADDR_BITWIDTH   = 4
);
  logic                                 load_start_i;
  logic [QUAN_SIZE-1:0]                 word_i;
  logic                                 word_valid_i;
  logic                                 word_ready_o;
  logic                                 mem_we_o;
  logic [ADDR_BITWIDTH-1:0]             mem_addr_o;
  logic [QUAN_SIZE*BANK_INTERLEAVE-1:0] mem_wdata_o;
  logic                                 busy_o;
  logic                                 done_o;

  modport master (
    output load_start_i, word_i, word_valid_i,
    input  word_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o
  );

  modport slave (
    input  load_start_i, word_i, word_valid_i,
    output word_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o
  );
endinterface

// File: rtl/lut_page_loader.sv
// Packs incoming LUT words MSB-first into pages and writes PAGE_NUM pages
// to the LUT page memory per load session.
module lut_page_loader #(
  parameter int QUAN_SIZE       = 3,
  parameter int PAGE_NUM        = 16,
  parameter int BANK_INTERLEAVE = 2,
  parameter int ADDR_BITWIDTH   = 4
) (
  input  logic             sys_clk,
  input  logic             rstn,
  lut_page_loader_if.slave bus
);
  localparam int PW  = QUAN_SIZE * BANK_INTERLEAVE;
  localparam int WCW = (BANK_INTERLEAVE > 1) ? $clog2(BANK_INTERLEAVE) : 1;
  localparam logic [WCW-1:0]           LAST_WORD = WCW'(BANK_INTERLEAVE - 1);
  localparam logic [ADDR_BITWIDTH-1:0] LAST_PAGE = ADDR_BITWIDTH'(PAGE_NUM - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                   state_q, state_d;
  logic [WCW-1:0]           word_cnt;
  logic [ADDR_BITWIDTH-1:0] page_cnt;
  logic [PW-1:0]            pack_q, pack_d;
  logic                     final_wr, accept, start_ok;
  int                       slot;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (bus.load_start_i) state_d = LOAD;
      LOAD:       if (final_wr)         state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // The write for the last page blocks further words; mem_addr_o already
  // holds that page's address during the write cycle.
  always_comb begin
    final_wr         = bus.mem_we_o && (bus.mem_addr_o == LAST_PAGE);
    bus.word_ready_o = (state_q == LOAD) && !final_wr;
    bus.busy_o       = (state_q == LOAD);
    bus.done_o       = (state_q == DONE);
    accept           = bus.word_ready_o && bus.word_valid_i;
    start_ok         = bus.load_start_i && (state_q != LOAD);
    slot             = BANK_INTERLEAVE - 1 - int'(word_cnt);
    pack_d           = pack_q;
    pack_d[slot*QUAN_SIZE +: QUAN_SIZE] = bus.word_i;
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      word_cnt        <= '0;
      page_cnt        <= '0;
      pack_q          <= '0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
    end else begin
      bus.mem_we_o <= 1'b0;
      if (start_ok) begin
        word_cnt <= '0;
        page_cnt <= '0;
        pack_q   <= '0;
      end else if (accept) begin
        pack_q <= pack_d;
        if (word_cnt == LAST_WORD) begin
          word_cnt        <= '0;
          bus.mem_we_o    <= 1'b1;
          bus.mem_addr_o  <= page_cnt;
          bus.mem_wdata_o <= pack_d;
          if (page_cnt != LAST_PAGE) page_cnt <= page_cnt + ADDR_BITWIDTH'(1);
        end else begin
          word_cnt <= word_cnt + WCW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_lut_page_loader.sv
// Bench for lut_page_loader: default build plus a 4-word, 4-bit, 8-page build.
module tb_lut_page_loader;
  logic sys_clk = 1'b0;
  logic rstn    = 1'b0;
  always #5 sys_clk = ~sys_clk;

  lut_page_loader_if #(.QUAN_SIZE(3), .BANK_INTERLEAVE(2), .ADDR_BITWIDTH(4)) bus_a ();
  lut_page_loader_if #(.QUAN_SIZE(4), .BANK_INTERLEAVE(4), .ADDR_BITWIDTH(3)) bus_b ();

  lut_page_loader #(.QUAN_SIZE(3), .PAGE_NUM(16), .BANK_INTERLEAVE(2), .ADDR_BITWIDTH(4))
    dut_a (.sys_clk(sys_clk), .rstn(rstn), .bus(bus_a));
  lut_page_loader #(.QUAN_SIZE(4), .PAGE_NUM(8), .BANK_INTERLEAVE(4), .ADDR_BITWIDTH(3))
    dut_b (.sys_clk(sys_clk), .rstn(rstn), .bus(bus_b));

  typedef struct {
    int unsigned addr;
    int unsigned data;
    int          cyc;
  } wr_t;

  wr_t got_a[$], got_b[$], exp_a[$], exp_b[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc   = 0;

  always @(posedge sys_clk) cyc++;

  always @(negedge sys_clk) begin
    if (bus_a.mem_we_o === 1'b1)
      got_a.push_back('{addr: 32'(bus_a.mem_addr_o), data: 32'(bus_a.mem_wdata_o), cyc: cyc});
    if (bus_b.mem_we_o === 1'b1)
      got_b.push_back('{addr: 32'(bus_b.mem_addr_o), data: 32'(bus_b.mem_wdata_o), cyc: cyc});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic start_a();
    bus_a.load_start_i = 1'b1;
    @(posedge sys_clk); #1;
    bus_a.load_start_i = 1'b0;
  endtask

  // Drives n words into DUT A and pushes the expected page writes.
  task automatic drive_a(input int n, input int mode, input int max_gap, input int start_at);
    int unsigned w, acc;
    int          g, tries;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin
        bus_a.word_valid_i = 1'b0;
        @(posedge sys_clk); #1;
      end
      w = (mode == 0) ? (i % 8) : ((7 - i) & 7);
      bus_a.word_i       = 3'(w);
      bus_a.word_valid_i = 1'b1;
      bus_a.load_start_i = (i == start_at);
      acc = (acc << 3) | w;
      if (i % 2 == 1) begin
        exp_a.push_back('{addr: i / 2, data: acc & 63, cyc: 0});
        acc = 0;
      end
      tries = 0;
      forever begin
        @(negedge sys_clk);
        if (bus_a.word_ready_o === 1'b1) break;
        tries++;
        if (tries > 8) break;
      end
      if (tries > 8) begin
        n_cmp++; n_bad++;
        $display("FAIL ready_timeout: got word_ready_o=0 for word %0d, expected 1", i);
      end
      @(posedge sys_clk); #1;
      bus_a.load_start_i = 1'b0;
    end
    bus_a.word_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    bus_a.load_start_i = 0; bus_a.word_i = '0; bus_a.word_valid_i = 0;
    bus_b.load_start_i = 0; bus_b.word_i = '0; bus_b.word_valid_i = 0;
    rstn = 1'b0;
    #12;
    n_cmp++;
    if ({bus_a.mem_we_o, bus_a.mem_addr_o, bus_a.mem_wdata_o, bus_a.word_ready_o,
         bus_a.busy_o, bus_a.done_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_a: got we=%b addr=%0d data=%0d rdy=%b busy=%b done=%b, expected all 0",
               bus_a.mem_we_o, bus_a.mem_addr_o, bus_a.mem_wdata_o, bus_a.word_ready_o,
               bus_a.busy_o, bus_a.done_o);
    end
    n_cmp++;
    if ({bus_b.mem_we_o, bus_b.mem_addr_o, bus_b.mem_wdata_o, bus_b.word_ready_o,
         bus_b.busy_o, bus_b.done_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_b: got we=%b addr=%0d data=%0d, expected all 0",
               bus_b.mem_we_o, bus_b.mem_addr_o, bus_b.mem_wdata_o);
    end
    @(posedge sys_clk); #1;
    rstn = 1'b1;
    @(posedge sys_clk); #1;
  endtask

  task automatic test_full_load();
    int prev;
    got_a.delete(); exp_a.delete();
    start_a();
    drive_a(32, 0, 0, -1);
    @(negedge sys_clk);
    n_cmp++;
    if (bus_a.mem_we_o !== 1'b1 || bus_a.mem_addr_o !== 4'd15 || bus_a.word_ready_o !== 1'b0
        || bus_a.done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL final_write: got we=%b addr=%0d rdy=%b done=%b, expected we=1 addr=15 rdy=0 done=0",
               bus_a.mem_we_o, bus_a.mem_addr_o, bus_a.word_ready_o, bus_a.done_o);
    end
    @(negedge sys_clk);
    n_cmp++;
    if (bus_a.done_o !== 1'b1 || bus_a.busy_o !== 1'b0 || bus_a.mem_we_o !== 1'b0) begin
      n_bad++;
      $display("FAIL done_after_load: got done=%b busy=%b we=%b, expected done=1 busy=0 we=0",
               bus_a.done_o, bus_a.busy_o, bus_a.mem_we_o);
    end
    @(posedge sys_clk); #1;
    n_cmp++;
    if (got_a.size() != exp_a.size()) begin
      n_bad++;
      $display("FAIL full_count: got %0d writes, expected %0d", got_a.size(), exp_a.size());
    end
    prev = -1;
    while (got_a.size() > 0 && exp_a.size() > 0) begin
      wr_t g, e;
      g = got_a.pop_front(); e = exp_a.pop_front();
      n_cmp++;
      if (g.addr != e.addr || g.data != e.data) begin
        n_bad++;
        $display("FAIL full_write: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                 g.addr, g.data, e.addr, e.data);
      end
      if (prev >= 0) begin
        n_cmp++;
        if (g.cyc - prev != 2) begin
          n_bad++;
          $display("FAIL write_spacing: got %0d cycles, expected 2", g.cyc - prev);
        end
      end
      prev = g.cyc;
    end
  endtask

  task automatic test_reload();
    got_a.delete(); exp_a.delete();
    bus_a.load_start_i = 1'b1;
    @(negedge sys_clk);
    n_cmp++;
    if (bus_a.done_o !== 1'b1) begin
      n_bad++;
      $display("FAIL done_in_start_cycle: got %b, expected 1", bus_a.done_o);
    end
    @(posedge sys_clk); #1;
    bus_a.load_start_i = 1'b0;
    @(negedge sys_clk);
    n_cmp++;
    if (bus_a.done_o !== 1'b0 || bus_a.busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL done_drop: got done=%b busy=%b, expected done=0 busy=1",
               bus_a.done_o, bus_a.busy_o);
    end
    @(posedge sys_clk); #1;
    drive_a(32, 1, 0, -1);
    repeat (3) @(posedge sys_clk);
    #1;
    n_cmp++;
    if (got_a.size() == 0 || got_a[0].data != 32'd62 || got_a[0].addr != 0) begin
      n_bad++;
      $display("FAIL reload_page0: got %0d writes, first data=%0d, expected data=62 at addr 0",
               got_a.size(), (got_a.size() > 0) ? got_a[0].data : 0);
    end
    n_cmp++;
    if (got_a.size() != exp_a.size()) begin
      n_bad++;
      $display("FAIL reload_count: got %0d writes, expected %0d", got_a.size(), exp_a.size());
    end
    while (got_a.size() > 0 && exp_a.size() > 0) begin
      wr_t g, e;
      g = got_a.pop_front(); e = exp_a.pop_front();
      n_cmp++;
      if (g.addr != e.addr || g.data != e.data) begin
        n_bad++;
        $display("FAIL reload_write: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                 g.addr, g.data, e.addr, e.data);
      end
    end
  endtask

  task automatic test_gaps();
    got_a.delete(); exp_a.delete();
    start_a();
    drive_a(32, 0, 3, -1);
    repeat (3) @(posedge sys_clk);
    #1;
    n_cmp++;
    if (got_a.size() != exp_a.size() || bus_a.done_o !== 1'b1) begin
      n_bad++;
      $display("FAIL gaps_count: got %0d writes done=%b, expected %0d writes done=1",
               got_a.size(), bus_a.done_o, exp_a.size());
    end
    while (got_a.size() > 0 && exp_a.size() > 0) begin
      wr_t g, e;
      g = got_a.pop_front(); e = exp_a.pop_front();
      n_cmp++;
      if (g.addr != e.addr || g.data != e.data) begin
        n_bad++;
        $display("FAIL gaps_write: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                 g.addr, g.data, e.addr, e.data);
      end
    end
  endtask

  task automatic test_start_during_load();
    got_a.delete(); exp_a.delete();
    start_a();
    drive_a(32, 0, 0, 5);
    repeat (3) @(posedge sys_clk);
    #1;
    n_cmp++;
    if (got_a.size() != 16 || got_a[2].addr != 2 || got_a[2].data != ((4 << 3) | 5)) begin
      n_bad++;
      $display("FAIL start_in_load: got %0d writes, third addr=%0d data=%0d, expected 16, addr=2 data=37",
               got_a.size(), (got_a.size() > 2) ? got_a[2].addr : 0,
               (got_a.size() > 2) ? got_a[2].data : 0);
    end
    while (got_a.size() > 0 && exp_a.size() > 0) begin
      wr_t g, e;
      g = got_a.pop_front(); e = exp_a.pop_front();
      n_cmp++;
      if (g.addr != e.addr || g.data != e.data) begin
        n_bad++;
        $display("FAIL start_in_load_write: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                 g.addr, g.data, e.addr, e.data);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    got_a.delete(); exp_a.delete();
    start_a();
    drive_a(7, 0, 0, -1);
    #1;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({bus_a.mem_we_o, bus_a.mem_addr_o, bus_a.mem_wdata_o, bus_a.word_ready_o,
         bus_a.busy_o, bus_a.done_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: got we=%b addr=%0d data=%0d rdy=%b busy=%b done=%b, expected all 0",
               bus_a.mem_we_o, bus_a.mem_addr_o, bus_a.mem_wdata_o, bus_a.word_ready_o,
               bus_a.busy_o, bus_a.done_o);
    end
    @(posedge sys_clk); #1;
    rstn = 1'b1;
    bus_a.word_valid_i = 1'b1;
    bus_a.word_i       = 3'd5;
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clk);
      n_cmp++;
      if (bus_a.mem_we_o !== 1'b0 || bus_a.word_ready_o !== 1'b0) begin
        n_bad++;
        $display("FAIL post_reset_idle: cycle %0d got we=%b rdy=%b, expected 0 0",
                 c, bus_a.mem_we_o, bus_a.word_ready_o);
      end
    end
    @(posedge sys_clk); #1;
    bus_a.word_valid_i = 1'b0;
    n_cmp++;
    if (got_a.size() != exp_a.size()) begin
      n_bad++;
      $display("FAIL reset_mid_count: got %0d writes, expected %0d", got_a.size(), exp_a.size());
    end
    while (got_a.size() > 0 && exp_a.size() > 0) begin
      wr_t g, e;
      g = got_a.pop_front(); e = exp_a.pop_front();
      n_cmp++;
      if (g.addr != e.addr || g.data != e.data) begin
        n_bad++;
        $display("FAIL reset_mid_write: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                 g.addr, g.data, e.addr, e.data);
      end
    end
  endtask

  task automatic test_sweep();
    int unsigned w, acc, w0;
    int          tries;
    got_b.delete(); exp_b.delete();
    bus_b.load_start_i = 1'b1;
    @(posedge sys_clk); #1;
    bus_b.load_start_i = 1'b0;
    acc = 0;
    w0  = 3;
    for (int i = 0; i < 32; i++) begin
      w = (i * 5 + 3) % 16;
      bus_b.word_i       = 4'(w);
      bus_b.word_valid_i = 1'b1;
      acc = (acc << 4) | w;
      if (i % 4 == 3) begin
        exp_b.push_back('{addr: i / 4, data: acc & 32'hFFFF, cyc: 0});
        acc = 0;
      end
      tries = 0;
      forever begin
        @(negedge sys_clk);
        if (bus_b.word_ready_o === 1'b1) break;
        tries++;
        if (tries > 8) break;
      end
      if (tries > 8) begin
        n_cmp++; n_bad++;
        $display("FAIL sweep_ready_timeout: got word_ready_o=0 for word %0d, expected 1", i);
      end
      @(posedge sys_clk); #1;
    end
    bus_b.word_valid_i = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    n_cmp++;
    if (got_b.size() != 8 || bus_b.done_o !== 1'b1 || bus_b.busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL sweep_done: got %0d writes done=%b busy=%b, expected 8 writes done=1 busy=0",
               got_b.size(), bus_b.done_o, bus_b.busy_o);
    end
    n_cmp++;
    if (got_b.size() == 0 || ((got_b[0].data >> 12) & 15) != w0) begin
      n_bad++;
      $display("FAIL sweep_msb_first: got top nibble %0d, expected %0d",
               (got_b.size() > 0) ? ((got_b[0].data >> 12) & 15) : 0, w0);
    end
    while (got_b.size() > 0 && exp_b.size() > 0) begin
      wr_t g, e;
      g = got_b.pop_front(); e = exp_b.pop_front();
      n_cmp++;
      if (g.addr != e.addr || g.data != e.data) begin
        n_bad++;
        $display("FAIL sweep_write: got addr=%0d data=%0h, expected addr=%0d data=%0h",
                 g.addr, g.data, e.addr, e.data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_reload();
    test_gaps();
    test_start_during_load();
    test_reset_mid_load();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
